// File: rtl/serialize_pkg.sv
// serialize_pkg
//   Shared helpers for the serialize block.
//   clamp_len: limits a requested element count to the vector capacity.
package serialize_pkg;

    function automatic int clamp_len(input int len, input int n);
        return (len > n) ? n : len;
    endfunction

endpackage

// File: rtl/serialize.sv
// serialize
//   Accepts a packed vector of up to N elements and emits its elements one
//   per result handshake, element 0 first. Each burst is followed by GAP idle
//   cycles so a downstream burst-end detector always sees res_stb low before
//   the next burst begins.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | vec_rdy high; waiting for a vector handshake
//   SEND  | res_stb high; presenting element idx of the registered vector
//   GAP   | res_stb and vec_rdy low; down-counting the inter-burst gap
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   vec_stb  in   input vector valid
//   vec_dat  in   packed vector, element k at [k*ARGW +: ARGW]
//   vec_len  in   number of elements to emit (clamped to N)
//   vec_rdy  out  module accepts a vector
//   res_stb  out  output element valid
//   res_dat  out  output element
//   res_rdy  in   downstream accepts element
module serialize
    import serialize_pkg::*;
#(
    parameter int ARGW = 32,
    parameter int N    = 4,
    parameter int GAP  = 2,
    localparam int CNTW = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vec_stb,
    input  logic [N*ARGW-1:0]   vec_dat,
    input  logic [CNTW-1:0]     vec_len,
    output logic                vec_rdy,
    output logic                res_stb,
    output logic [ARGW-1:0]     res_dat,
    input  logic                res_rdy
);

    localparam int GW = $clog2(GAP + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [N*ARGW-1:0] vec_q;
    logic [CNTW-1:0]   len_q;
    logic [CNTW-1:0]   idx;
    logic [CNTW-1:0]   len_eff;
    logic [GW-1:0]     gap_cnt;
    logic              vec_hs;
    logic              res_hs;
    logic              last_elem;

    assign len_eff   = CNTW'(clamp_len(int'(vec_len), N));
    assign vec_hs    = vec_stb & vec_rdy;
    assign res_hs    = res_stb & res_rdy;
    // idx never exceeds N-1, so idx+1 fits in CNTW bits.
    assign last_elem = ((idx + CNTW'(1)) == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (vec_hs && (len_eff != '0)) state_nxt = S_SEND;
            S_SEND: if (res_hs && last_elem)       state_nxt = S_GAP;
            S_GAP:  if (gap_cnt <= GW'(1))         state_nxt = S_IDLE;
            default:                               state_nxt = S_IDLE;
        endcase
    end

    // idx is returned to 0 at burst end so the part-select below always
    // addresses a real element and res_dat is never X.
    always_comb begin
        vec_rdy = (state == S_IDLE);
        res_stb = (state == S_SEND);
        res_dat = vec_q[ARGW*int'(idx) +: ARGW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q   <= '0;
            len_q   <= '0;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (vec_hs) begin
                        vec_q <= vec_dat;
                        len_q <= len_eff;
                        idx   <= '0;
                    end
                end
                S_SEND: begin
                    if (res_hs) begin
                        if (last_elem) begin
                            idx     <= '0;
                            gap_cnt <= GW'(GAP);
                        end else begin
                            idx <= idx + CNTW'(1);
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serialize.sv
module tb_serialize;

    localparam int ARGW = 8;
    localparam int N    = 4;
    localparam int GAP  = 2;
    localparam int CNTW = $clog2(N + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                vec_stb = 1'b0;
    logic [N*ARGW-1:0]   vec_dat = '0;
    logic [CNTW-1:0]     vec_len = '0;
    logic                vec_rdy;
    logic                res_stb;
    logic [ARGW-1:0]     res_dat;
    logic                res_rdy = 1'b1;

    int errors = 0;
    int checks = 0;
    bit rand_rdy = 1'b0;

    logic [7:0]  exp_dat_q[$];
    int          exp_len_q[$];
    logic [15:0] exp_acc_q[$];

    serialize #(.ARGW(ARGW), .N(N), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .vec_stb (vec_stb),
        .vec_dat (vec_dat),
        .vec_len (vec_len),
        .vec_rdy (vec_rdy),
        .res_stb (res_stb),
        .res_dat (res_dat),
        .res_rdy (res_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a vector yields its first min(len,N) bytes in order;
    // the accumulator result is the signed sum of those bytes, 16-bit wrap.
    task automatic model_push(input logic [31:0] dat, input int len);
        int l;
        int s;
        logic [7:0] b;
        l = (len > N) ? N : len;
        s = 0;
        for (int k = 0; k < l; k++) begin
            b = dat[k*8 +: 8];
            exp_dat_q.push_back(b);
            s += int'($signed(b));
        end
        if (l > 0) begin
            exp_len_q.push_back(l);
            exp_acc_q.push_back(16'(s));
        end
    endtask

    task automatic send(input logic [31:0] dat, input int len);
        int w;
        w = 0;
        while (!vec_rdy && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!vec_rdy) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: vec_rdy stayed %0b, required 1", vec_rdy);
        end else begin
            vec_stb = 1'b1;
            vec_dat = dat;
            vec_len = CNTW'(len);
            model_push(dat, len);
            @(posedge clk); #1;
            vec_stb = 1'b0;
        end
    endtask

    task automatic drain;
        int w;
        w = 0;
        while ((exp_dat_q.size() != 0 || exp_len_q.size() != 0 || !vec_rdy) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_dat_q", exp_dat_q.size(), 0);
        check("drain_len_q", exp_len_q.size(), 0);
    endtask

    task automatic next_cycle;
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 res_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations on each result handshake, tracks burst
    // length, accumulator and the inter-burst idle count.
    bit          in_burst = 0;
    int          burst_cnt = 0;
    int          low_cnt = 100;
    logic [15:0] acc = '0;
    bit          prev_stall = 0;
    logic [7:0]  prev_dat = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_burst   = 0;
            burst_cnt  = 0;
            acc        = '0;
            low_cnt    = 100;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_stb_hold", res_stb, 1'b1);
                check("stall_dat_hold", res_dat, prev_dat);
            end
            if (res_stb) begin
                if (!in_burst) begin
                    checks++;
                    if (low_cnt < GAP + 1) begin
                        errors++;
                        $display("FAIL burst_gap: idle cycles %0d, required >= %0d", low_cnt, GAP + 1);
                    end
                    in_burst  = 1;
                    burst_cnt = 0;
                    acc       = '0;
                end
                if (res_rdy) begin
                    if (exp_dat_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_elem: got %0h, required none", res_dat);
                    end else begin
                        check("elem_data", res_dat, exp_dat_q.pop_front());
                    end
                    burst_cnt++;
                    acc = acc + {{8{res_dat[7]}}, res_dat};
                end
            end else begin
                if (in_burst) begin
                    if (exp_len_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_burst: length %0d, required none", burst_cnt);
                    end else begin
                        check("burst_len", burst_cnt, exp_len_q.pop_front());
                        check("accum", acc, exp_acc_q.pop_front());
                    end
                    in_burst = 0;
                    low_cnt  = 1;
                end else begin
                    low_cnt++;
                end
            end
            prev_stall = res_stb & ~res_rdy;
            prev_dat   = res_dat;
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) next_cycle();
        check("rst_res_stb", res_stb, 1'b0);
        check("rst_vec_rdy", vec_rdy, 1'b1);
        check("rst_res_dat", res_dat, 8'h00);
        rst = 1'b0;
        next_cycle();
        check("post_rst_vec_rdy", vec_rdy, 1'b1);

        // Basic burst with exact timing, handshake at cycle t
        send(32'h04030201, 4);
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("timing_stb_t%0d", i), res_stb, (i <= 4) ? 1'b1 : 1'b0);
            check($sformatf("timing_rdy_t%0d", i), vec_rdy, (i == 7) ? 1'b1 : 1'b0);
            if (i <= 4) check($sformatf("timing_dat_t%0d", i), res_dat, 8'(i));
            if (i < 7) next_cycle();
        end

        // Backpressure while 0x02 is shown
        send(32'h04030201, 4);
        next_cycle();
        res_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_stb", res_stb, 1'b1);
            check("stall_dat", res_dat, 8'h02);
            next_cycle();
        end
        res_rdy = 1'b1;
        drain();

        // Zero length is dropped; oversize length clamps to N
        send(32'hAABBCCDD, 0);
        check("len0_stb", res_stb, 1'b0);
        check("len0_rdy", vec_rdy, 1'b1);
        send(32'h44332211, 6);
        drain();

        // Back-to-back vectors into the accumulator: 0x000A then 0xFFFC
        send(32'h04030201, 4);
        send(32'hFFFFFFFF, 4);
        drain();

        // Reset on the cycle after element 1's handshake
        send(32'h44332211, 4);
        next_cycle();
        rst = 1'b1;
        exp_dat_q.delete();
        exp_len_q.delete();
        exp_acc_q.delete();
        next_cycle();
        rst = 1'b0;
        check("abort_stb", res_stb, 1'b0);
        check("abort_rdy", vec_rdy, 1'b1);
        send(32'h0D0C0B0A, 4);
        check("abort_first", res_dat, 8'h0A);
        drain();

        // Randomized vectors with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send($urandom, int'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) next_cycle();
        end
        drain();
        rand_rdy = 1'b0;
        #2 res_rdy = 1'b1;
        repeat (5) next_cycle();
        check("final_idle_rdy", vec_rdy, 1'b1);
        check("final_acc_q", exp_acc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
